wb_regfile: RTL and testbench

Write-back end of the CPU pipeline: consumes the MEM/WB latch outputs and commits them into architectural state, namely the 32×32 general register file, the HI/LO multiply-result pair and the flags register. Exposes two combinational GPR read ports to decode, plus HI/LO/flags read outputs. Same-cycle write-to-read bypass removes the WB→ID read-after-write hazard.

---
 rtl/wb_regfile_pkg.sv | 16 +
 rtl/wb_regfile_if.sv | 40 ++++
 rtl/hilo_flags_reg.sv | 55 +++++
 rtl/wb_regfile.sv | 68 ++++++
 tb/tb_wb_regfile.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage: widths, register count and
// the enable/reset encodings used across the register-file slice.
package wb_regfile_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic RST_ENABLE   = 1'b0;  // reset is active-low
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB commit bus plus the decode-side read ports of the register file.
// The pipeline is the master; the register file is the slave.
interface wb_regfile_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_we;
    logic [DATA_W-1:0] wb_flags;

    logic              re1;
    logic              re2;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic [DATA_W-1:0] flags_o;
    logic [DATA_W-1:0] flags_snap;  // last committed flags, for exception capture

    modport master (
        output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_we, wb_flags,
        output re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, flags_o, flags_snap
    );

    modport slave (
        input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_we, wb_flags,
        input  re1, re2, raddr1, raddr2,
        output rdata1, rdata2, hi_o, lo_o, flags_o, flags_snap
    );

endinterface

// File: rtl/hilo_flags_reg.sv
// HI/LO multiply-result pair and the flags register, each with a
// same-cycle bypass from the write-back inputs.
module hilo_flags_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic [DATA_W-1:0] flags_in,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] flags_o,
    output logic [DATA_W-1:0] flags_snap
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] flags_q;

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_q    <= '0;
            lo_q    <= '0;
            flags_q <= '0;
        end else begin
            if (we == WRITE_ENABLE) begin
                hi_q <= hi_in;
                lo_q <= lo_in;
            end
            flags_q <= flags_in;
        end
    end

    // NOTE: outputs get a default before any branch so no latch is inferred.
    always_comb begin
        hi_o       = '0;
        lo_o       = '0;
        flags_o    = '0;
        flags_snap = '0;
        if (rst != RST_ENABLE) begin
            hi_o       = (we == WRITE_ENABLE) ? hi_in : hi_q;
            lo_o       = (we == WRITE_ENABLE) ? lo_in : lo_q;
            // Flags are written every cycle, so the bypass always wins.
            flags_o    = flags_in;
            flags_snap = flags_q;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back commit: 32x32 GPR file with two bypassed combinational read
// ports, plus HI/LO and flags held in hilo_flags_reg.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int NREGS  = REG_NUM,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] regs [NREGS];

    // NOTE: the array is cleared by reset because software expects every GPR
    // to read zero after reset; this costs a flop-array rather than a RAM.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_wreg == WRITE_ENABLE && bus.wb_wd != NOP_REG_ADDR) begin
            regs[bus.wb_wd] <= bus.wb_wdata;
        end
    end

    // r0 is checked before the bypass so a dropped write to r0 never leaks.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_v,
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic              wreg,
        input logic [ADDR_W-1:0] wd,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (rst_v == RST_ENABLE)                    return ZERO_WORD;
        if (re != READ_ENABLE)                      return ZERO_WORD;
        if (raddr == NOP_REG_ADDR)                  return ZERO_WORD;
        if (wreg == WRITE_ENABLE && raddr == wd)    return wdata;
        return stored;
    endfunction

    always_comb begin
        bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, bus.wb_wreg, bus.wb_wd,
                               bus.wb_wdata, regs[bus.raddr1]);
        bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, bus.wb_wreg, bus.wb_wd,
                               bus.wb_wdata, regs[bus.raddr2]);
    end

    hilo_flags_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_flags (
        .clk        (clk),
        .rst        (rst),
        .we         (bus.wb_we),
        .hi_in      (bus.wb_hi),
        .lo_in      (bus.wb_lo),
        .flags_in   (bus.wb_flags),
        .hi_o       (bus.hi_o),
        .lo_o       (bus.lo_o),
        .flags_o    (bus.flags_o),
        .flags_snap (bus.flags_snap)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/read, bypass, r0, HI/LO,
// flags, back-to-back writes and reset during a write.
module tb_wb_regfile;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    wb_regfile_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled mid-cycle, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_wd    = '0;
        bus.wb_wreg  = 1'b0;
        bus.wb_wdata = '0;
        bus.wb_hi    = '0;
        bus.wb_lo    = '0;
        bus.wb_we    = 1'b0;
        bus.wb_flags = '0;
        bus.re1      = 1'b1;
        bus.re2      = 1'b1;
        bus.raddr1   = '0;
        bus.raddr2   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        // Active write attempts during reset must not show up anywhere.
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd5; bus.wb_wdata = 32'h77;
        bus.wb_we = 1'b1; bus.wb_hi = 32'h3; bus.wb_flags = 32'hF;
        bus.raddr1 = 5'd5;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL rst_hold_rdata1 got=%h exp=%h", bus.rdata1, 32'h0);
        else passed++;
        total++;
        if (bus.hi_o !== 32'h0 || bus.flags_o !== 32'h0)
            $display("FAIL rst_hold_hi_flags got=%h/%h exp=0/0", bus.hi_o, bus.flags_o);
        else passed++;
        step();
        // Preload r5 and HI, then reset again.
        rst = 1'b1;
        bus.wb_wdata = 32'h1234; bus.wb_hi = 32'h7; bus.wb_lo = 32'h0; bus.wb_flags = 32'h0;
        step();
        bus.wb_wreg = 1'b0; bus.wb_we = 1'b0;
        #1;
        total++;
        if (bus.rdata1 !== 32'h1234 || bus.hi_o !== 32'h7)
            $display("FAIL preload got=%h/%h exp=1234/7", bus.rdata1, bus.hi_o);
        else passed++;
        rst = 1'b0;
        bus.wb_flags = 32'h3;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0 || bus.hi_o !== 32'h0 || bus.flags_o !== 32'h0)
            $display("FAIL rst_comb got=%h/%h/%h exp=0/0/0", bus.rdata1, bus.hi_o, bus.flags_o);
        else passed++;
        step();
        rst = 1'b1;
        bus.wb_flags = 32'h0;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL rst_cleared_r5 got=%h exp=%h", bus.rdata1, 32'h0);
        else passed++;
        total++;
        if (bus.hi_o !== 32'h0 || bus.flags_snap !== 32'h0)
            $display("FAIL rst_cleared_hi_snap got=%h/%h exp=0/0", bus.hi_o, bus.flags_snap);
        else passed++;
    endtask

    task automatic test_write_read();
        idle_inputs();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd3; bus.wb_wdata = 32'hDEADBEEF;
        step();
        bus.wb_wreg = 1'b0; bus.wb_wdata = 32'h0;
        bus.raddr1 = 5'd3; bus.raddr2 = 5'd3;
        #1;
        total++;
        if (bus.rdata1 !== 32'hDEADBEEF) $display("FAIL wr_rd_port1 got=%h exp=%h", bus.rdata1, 32'hDEADBEEF);
        else passed++;
        total++;
        if (bus.rdata2 !== 32'hDEADBEEF) $display("FAIL wr_rd_port2 got=%h exp=%h", bus.rdata2, 32'hDEADBEEF);
        else passed++;
    endtask

    task automatic test_bypass();
        idle_inputs();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd7; bus.wb_wdata = 32'hA5A5A5A5;
        bus.raddr1 = 5'd7; bus.raddr2 = 5'd7;
        #1;
        total++;
        if (bus.rdata1 !== 32'hA5A5A5A5 || bus.rdata2 !== 32'hA5A5A5A5)
            $display("FAIL bypass_same got=%h/%h exp=a5a5a5a5", bus.rdata1, bus.rdata2);
        else passed++;
        // A write to r7 must not disturb a read of r3.
        bus.raddr1 = 5'd3;
        #1;
        total++;
        if (bus.rdata1 !== 32'hDEADBEEF || bus.rdata2 !== 32'hA5A5A5A5)
            $display("FAIL bypass_other got=%h/%h exp=deadbeef/a5a5a5a5", bus.rdata1, bus.rdata2);
        else passed++;
        step();
        bus.wb_wreg = 1'b0; bus.wb_wdata = 32'h0;
        bus.raddr1 = 5'd7;
        #1;
        total++;
        if (bus.rdata1 !== 32'hA5A5A5A5) $display("FAIL bypass_stored got=%h exp=%h", bus.rdata1, 32'hA5A5A5A5);
        else passed++;
    endtask

    task automatic test_r0();
        idle_inputs();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd0; bus.wb_wdata = 32'hFFFFFFFF;
        bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0)
            $display("FAIL r0_same_cycle got=%h/%h exp=0/0", bus.rdata1, bus.rdata2);
        else passed++;
        step();
        bus.wb_wreg = 1'b0; bus.wb_wdata = 32'h0;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0)
            $display("FAIL r0_next_cycle got=%h/%h exp=0/0", bus.rdata1, bus.rdata2);
        else passed++;
    endtask

    task automatic test_hilo_re();
        idle_inputs();
        bus.wb_we = 1'b1; bus.wb_hi = 32'h1; bus.wb_lo = 32'h2;
        #1;
        total++;
        if (bus.hi_o !== 32'h1 || bus.lo_o !== 32'h2)
            $display("FAIL hilo_bypass got=%h/%h exp=1/2", bus.hi_o, bus.lo_o);
        else passed++;
        step();
        bus.wb_we = 1'b0; bus.wb_hi = 32'hAA; bus.wb_lo = 32'hBB;
        #1;
        total++;
        if (bus.hi_o !== 32'h1 || bus.lo_o !== 32'h2)
            $display("FAIL hilo_hold got=%h/%h exp=1/2", bus.hi_o, bus.lo_o);
        else passed++;
        step();
        #1;
        total++;
        if (bus.hi_o !== 32'h1 || bus.lo_o !== 32'h2)
            $display("FAIL hilo_no_we_edge got=%h/%h exp=1/2", bus.hi_o, bus.lo_o);
        else passed++;
        bus.re2 = 1'b0; bus.raddr2 = 5'd3;
        bus.raddr1 = 5'd3;
        #1;
        total++;
        if (bus.rdata2 !== 32'h0 || bus.rdata1 !== 32'hDEADBEEF)
            $display("FAIL read_enable got=%h/%h exp=0/deadbeef", bus.rdata2, bus.rdata1);
        else passed++;
    endtask

    task automatic test_flags();
        idle_inputs();
        bus.wb_flags = 32'h5;
        #1;
        total++;
        if (bus.flags_o !== 32'h5) $display("FAIL flags_bypass got=%h exp=%h", bus.flags_o, 32'h5);
        else passed++;
        step();
        bus.wb_flags = 32'h9;
        #1;
        total++;
        if (bus.flags_o !== 32'h9 || bus.flags_snap !== 32'h5)
            $display("FAIL flags_snap got=%h/%h exp=9/5", bus.flags_o, bus.flags_snap);
        else passed++;
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd10; bus.wb_wdata = 32'h1;
        step();
        bus.wb_wdata = 32'h2;
        step();
        bus.wb_wreg = 1'b0; bus.wb_wdata = 32'h0;
        bus.raddr1 = 5'd10; bus.raddr2 = 5'd31;
        #1;
        total++;
        if (bus.rdata1 !== 32'h2) $display("FAIL back_to_back got=%h exp=%h", bus.rdata1, 32'h2);
        else passed++;
        total++;
        if (bus.rdata2 !== 32'h0) $display("FAIL untouched_r31 got=%h exp=%h", bus.rdata2, 32'h0);
        else passed++;
    endtask

    task automatic test_reset_mid_write();
        idle_inputs();
        rst = 1'b0;
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd9; bus.wb_wdata = 32'h55;
        step();
        rst = 1'b1;
        bus.wb_wreg = 1'b0; bus.wb_wdata = 32'h0;
        bus.raddr1 = 5'd9; bus.raddr2 = 5'd3;
        #1;
        total++;
        if (bus.rdata1 !== 32'h0) $display("FAIL rst_mid_write_r9 got=%h exp=%h", bus.rdata1, 32'h0);
        else passed++;
        total++;
        if (bus.rdata2 !== 32'h0 || bus.hi_o !== 32'h0)
            $display("FAIL rst_mid_write_clear got=%h/%h exp=0/0", bus.rdata2, bus.hi_o);
        else passed++;
        // First accepted write is the one at the first edge out of reset.
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd9; bus.wb_wdata = 32'h66;
        step();
        bus.wb_wreg = 1'b0; bus.wb_wdata = 32'h0;
        #1;
        total++;
        if (bus.rdata1 !== 32'h66) $display("FAIL first_write_after_rst got=%h exp=%h", bus.rdata1, 32'h66);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_hilo_re();
        test_flags();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
